router_fifo_pkt: RTL and testbench
==================================

Name: router_fifo_pkt

Overview:
Parametrised, packet-aware FIFO. It is the next-generation buffer between the router's synchroniser/FSM and each output port. Each entry carries a header flag alongside the data byte, which lets the read side track packet boundaries from the header's length field. Compared with the fixed 8x16 buffer it adds configurable width and depth, true full/empty via an extended pointer bit, a fill-level output, almost-full/almost-empty thresholds, error pulses and a registered output-valid qualifier in place of high-impedance output.

Parameters:
DATA_WIDTH, 8, data byte width; header length field is data[DATA_WIDTH-1:2] (LEN_W = DATA_WIDTH-2).
DEPTH, 16, number of entries; power of two, at least 4.
ADDR_W, $clog2(DEPTH), pointer index width (derived; not overridden).
AF_MARGIN, 2, almost_full asserts when free entries <= AF_MARGIN.
AE_MARGIN, 2, almost_empty asserts when fill_level <= AE_MARGIN.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  synchronous, active-high reset.
soft_reset  input  1  synchronous flush (read-timeout from the router FSM).
write_enb  input  1  write request.
lfd_state  input  1  marks data_in as a packet header byte.
data_in  input  DATA_WIDTH  write data.
read_enb  input  1  read request.
data_out  output  DATA_WIDTH  registered read data.
out_valid  output  1  data_out was loaded this cycle.
pkt_done  output  1  one-cycle pulse when the last byte (parity) of a packet is read.
full  output  1  DEPTH entries held.
empty  output  1  zero entries held.
almost_full  output  1  fill_level >= DEPTH-AF_MARGIN.
almost_empty  output  1  fill_level <= AE_MARGIN.
fill_level  output  ADDR_W+1  entries held, 0..DEPTH.
wr_err  output  1  one-cycle pulse: write_enb while full.
rd_err  output  1  one-cycle pulse: read_enb while empty.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1); bit DATA_WIDTH holds lfd_state. Memory is not cleared by reset or soft_reset.
- Pointers wr_ptr and rd_ptr are ADDR_W+1 bits wide; the low ADDR_W bits index memory.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits are equal.
  - fill_level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
  - All status outputs are combinational from the pointers.
- Write is accepted iff write_enb && !full. The entry is stored at wr_ptr and wr_ptr increments; it wraps naturally at 2^(ADDR_W+1).
- Read is accepted iff read_enb && !empty. On the next edge data_out <= mem[rd_ptr][DATA_WIDTH-1:0], out_valid <= 1, and rd_ptr increments. Latency is one cycle from accepted read to out_valid.
- When no read is accepted: out_valid <= 0 and data_out holds its last value. It is never driven to Z.
- Simultaneous read and write use the flags sampled at cycle start:
  - If full, the read is accepted, the write is rejected and wr_err pulses; the entry count drops by 1.
  - If empty, the write is accepted, the read is rejected and rd_err pulses; the entry count rises by 1.
  - Otherwise both are accepted and fill_level is unchanged.
- Packet counter pkt_cnt (LEN_W+1 bits, reset 0), updated on an accepted read:
  - Header entry (flag = 1): pkt_cnt <= len + 1, covering payload plus parity.
  - Non-header entry with pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1, and pkt_done pulses on the 1->0 transition (registered, aligned with out_valid).
  - Non-header entry with pkt_cnt == 0: treated as an orphan byte; pkt_cnt is unchanged and there is no pkt_done.
- Header with len = 0: pkt_cnt = 1, and the next non-header read completes the packet.
- Header read while pkt_cnt != 0: reloads the counter. The truncated packet gets no pkt_done.
- wr_err and rd_err are registered one-cycle pulses and are asserted in the cycle after the offending request.
- reset (highest priority) and soft_reset take identical action: wr_ptr, rd_ptr and pkt_cnt clear to 0; data_out = 0; out_valid, pkt_done, wr_err and rd_err = 0. Requests in that cycle are ignored.
- Flags after reset: empty = 1, almost_empty = 1, full = 0, almost_full = 0, fill_level = 0.
- A mid-packet soft_reset discards the packet, and no pkt_done is issued for it.

Test Plan:
- Reset, then write header 8'h0C (len=3, flag=1) followed by 4 bytes and read all 5 -> out_valid on 5 consecutive cycles after read_enb, data_out 0C,b1,b2,b3,parity; pkt_done only with parity; empty=1 at the end.
- DEPTH=16: 16 writes -> full=1, almost_full asserted from fill_level 14, fill_level=16. A 17th write -> wr_err pulses and data is not stored. Draining all 16 returns data in order across the pointer wrap.
- While full, simultaneous read+write -> read accepted, write rejected, fill_level=15. At fill_level=8, simultaneous read+write -> fill_level stays 8 and both are accepted.
- While empty, read_enb -> rd_err pulses, out_valid=0, data_out unchanged. Simultaneous write+read -> fill_level=1 and out_valid=0.
- Write a 6-entry packet, read 2 bytes, pulse soft_reset -> empty=1, fill_level=0, data_out=0, no pkt_done. A following packet reads correctly.
- Rerun the first scenario with DATA_WIDTH=16, DEPTH=64, header len=5 -> pkt_done on the 7th read and fill_level width of 7 bits.

Source files
------------

// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt: packet-aware FIFO with extended-pointer flags, fill level and per-packet completion pulse
module router_fifo_pkt #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int AF_MARGIN  = 2,
    parameter int AE_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  pkt_done,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_W:0]       fill_level,
    output logic                  wr_err,
    output logic                  rd_err
);
    localparam int LEN_W = DATA_WIDTH - 2;
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [ADDR_W:0]       wr_ptr, rd_ptr;
    logic [LEN_W:0]        pkt_cnt;
    logic [DATA_WIDTH:0]   rd_entry;
    logic                  wr_ok, rd_ok, clr;
    assign clr          = reset || soft_reset;
    assign empty        = wr_ptr == rd_ptr;
    assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign fill_level   = wr_ptr - rd_ptr;
    assign almost_full  = fill_level >= (ADDR_W+1)'(DEPTH - AF_MARGIN);
    assign almost_empty = fill_level <= (ADDR_W+1)'(AE_MARGIN);
    assign wr_ok        = write_enb && !full;
    assign rd_ok        = read_enb && !empty;
    assign rd_entry     = mem[rd_ptr[ADDR_W-1:0]];
    always_ff @(posedge clk)
        if (wr_ok && !clr) mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
    // Bit DATA_WIDTH of an entry is the header flag; header length sits above the two low data bits.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pkt_cnt   <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            pkt_done  <= 1'b0;
            wr_err    <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + (ADDR_W+1)'(wr_ok);
            rd_ptr    <= rd_ptr + (ADDR_W+1)'(rd_ok);
            out_valid <= rd_ok;
            wr_err    <= write_enb && full;
            rd_err    <= read_enb && empty;
            pkt_done  <= rd_ok && !rd_entry[DATA_WIDTH] && pkt_cnt == (LEN_W+1)'(1);
            if (rd_ok) begin
                data_out <= rd_entry[DATA_WIDTH-1:0];
                if (rd_entry[DATA_WIDTH]) pkt_cnt <= {1'b0, rd_entry[DATA_WIDTH-1:2]} + 1'b1;
                else if (pkt_cnt != '0) pkt_cnt <= pkt_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_router_fifo_pkt.sv
// tb_router_fifo_pkt: table vectors plus queue scoreboard for the 8x16 and 16x64 FIFO configurations
module tb_router_fifo_pkt;
    logic clk = 0, rst = 1, sr = 0, we = 0, lfd = 0, re = 0;
    logic [7:0] din = 0, dout;
    logic ov, pd, fu, em, af, ae, wer, rer;
    logic [4:0] fl;
    logic w2 = 0, l2 = 0, r2 = 0;
    logic [15:0] d2 = 0, dout2;
    logic ov2, pd2, fu2, em2, af2, ae2, wer2, rer2;
    logic [6:0] fl2;
    int n_chk = 0, n_err = 0;
    logic [8:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_dout = 0;
    logic [6:0] m_cnt = 0;
    logic exp_ov = 0, exp_pd = 0, exp_we = 0, exp_re = 0;
    typedef struct {
        logic w, l;
        logic [7:0] d;
        logic r;
        logic [4:0] fl;
        logic ov;
        logic [7:0] dout;
        logic pd;
    } vec_t;
    vec_t tbl[11];
    logic [15:0] wexp[7];

    always #5 clk = ~clk;

    router_fifo_pkt u8 (
        .clk(clk), .reset(rst), .soft_reset(sr), .write_enb(we), .lfd_state(lfd), .data_in(din),
        .read_enb(re), .data_out(dout), .out_valid(ov), .pkt_done(pd), .full(fu), .empty(em),
        .almost_full(af), .almost_empty(ae), .fill_level(fl), .wr_err(wer), .rd_err(rer));

    router_fifo_pkt #(.DATA_WIDTH(16), .DEPTH(64)) u16 (
        .clk(clk), .reset(rst), .soft_reset(1'b0), .write_enb(w2), .lfd_state(l2), .data_in(d2),
        .read_enb(r2), .data_out(dout2), .out_valid(ov2), .pkt_done(pd2), .full(fu2), .empty(em2),
        .almost_full(af2), .almost_empty(ae2), .fill_level(fl2), .wr_err(wer2), .rd_err(rer2));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = m_q.size();
        chk("out_valid", 32'(ov), 32'(exp_ov));
        if (ov) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL scoreboard: got read %0h expected no read", dout);
            end else chk("scoreboard", 32'(dout), 32'(exp_q.pop_front()));
        end
        chk("data_out", 32'(dout), 32'(exp_dout));
        chk("pkt_done", 32'(pd), 32'(exp_pd));
        chk("fill_level", 32'(fl), 32'(sz));
        chk("empty", 32'(em), 32'(sz == 0));
        chk("full", 32'(fu), 32'(sz == 16));
        chk("almost_full", 32'(af), 32'(sz >= 14));
        chk("almost_empty", 32'(ae), 32'(sz <= 2));
        chk("wr_err", 32'(wer), 32'(exp_we));
        chk("rd_err", 32'(rer), 32'(exp_re));
    endtask

    task automatic step(input logic w, input logic l, input logic [7:0] d, input logic r, input logic s);
        logic [8:0] e;
        logic wok, rok;
        we = w; lfd = l; din = d; re = r; sr = s;
        wok = w && m_q.size() != 16;
        rok = r && m_q.size() != 0;
        exp_ov = 0; exp_pd = 0; exp_we = w && !wok; exp_re = r && !rok;
        if (s) begin
            m_q.delete(); exp_q.delete();
            m_cnt = 0; exp_dout = 0; exp_we = 0; exp_re = 0;
        end else begin
            if (rok) begin
                e = m_q.pop_front();
                exp_ov = 1;
                exp_dout = e[7:0];
                exp_q.push_back(e[7:0]);
                if (e[8]) m_cnt = {1'b0, e[7:2]} + 7'd1;
                else if (m_cnt != 0) begin
                    m_cnt = m_cnt - 7'd1;
                    exp_pd = m_cnt == 0;
                end
            end
            if (wok) m_q.push_back({l, d});
        end
        @(posedge clk); #1;
        we = 0; lfd = 0; re = 0; sr = 0;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1; we = 0; re = 0; sr = 0; w2 = 0; r2 = 0;
        @(posedge clk); #1;
        rst = 0;
        m_q.delete(); exp_q.delete();
        m_cnt = 0; exp_dout = 0; exp_ov = 0; exp_pd = 0; exp_we = 0; exp_re = 0;
        check_all();
    endtask

    initial begin
        tbl = '{
            '{1, 1, 8'h0C, 0, 5'd1, 0, 8'h00, 0},
            '{1, 0, 8'hB1, 0, 5'd2, 0, 8'h00, 0},
            '{1, 0, 8'hB2, 0, 5'd3, 0, 8'h00, 0},
            '{1, 0, 8'hB3, 0, 5'd4, 0, 8'h00, 0},
            '{1, 0, 8'h5A, 0, 5'd5, 0, 8'h00, 0},
            '{0, 0, 8'h00, 1, 5'd4, 1, 8'h0C, 0},
            '{0, 0, 8'h00, 1, 5'd3, 1, 8'hB1, 0},
            '{0, 0, 8'h00, 1, 5'd2, 1, 8'hB2, 0},
            '{0, 0, 8'h00, 1, 5'd1, 1, 8'hB3, 0},
            '{0, 0, 8'h00, 1, 5'd0, 1, 8'h5A, 1},
            '{0, 0, 8'h00, 1, 5'd0, 0, 8'h5A, 0}
        };
        @(posedge clk); #1;
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].w, tbl[i].l, tbl[i].d, tbl[i].r, 0);
            chk("tbl_fill", 32'(fl), 32'(tbl[i].fl));
            chk("tbl_valid", 32'(ov), 32'(tbl[i].ov));
            chk("tbl_dout", 32'(dout), 32'(tbl[i].dout));
            chk("tbl_pkt_done", 32'(pd), 32'(tbl[i].pd));
        end
        chk("tbl_empty_end", 32'(em), 32'd1);
        // fill across pointer wrap, overflow, full/half simultaneous ops, drain
        for (int i = 0; i < 16; i++) step(1, 0, 8'h10 + 8'(i), 0, 0);
        chk("full_level", 32'(fl), 32'd16);
        step(1, 0, 8'hFF, 0, 0);
        step(1, 0, 8'hEE, 1, 0);
        chk("full_rw_level", 32'(fl), 32'd15);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, 0);
        step(1, 0, 8'hDD, 1, 0);
        chk("half_rw_level", 32'(fl), 32'd8);
        for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, 0);
        // empty corner cases
        step(0, 0, 8'h00, 1, 0);
        step(1, 0, 8'h77, 1, 0);
        chk("empty_rw_level", 32'(fl), 32'd1);
        step(0, 0, 8'h00, 1, 0);
        // mid-packet soft reset, then a clean packet
        step(1, 1, 8'h10, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'hA0 + 8'(i), 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        chk("sr_dout", 32'(dout), 32'd0);
        step(1, 1, 8'h08, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'hC0 + 8'(i), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
        // zero-length header and header reload mid-packet
        step(1, 1, 8'h00, 0, 0);
        step(1, 0, 8'h33, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(1, 1, 8'h0C, 0, 0);
        step(1, 0, 8'h44, 0, 0);
        step(1, 1, 8'h04, 0, 0);
        step(1, 0, 8'h55, 0, 0);
        step(1, 0, 8'h66, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
        // wide configuration: 16-bit data, 64 entries, header len=5
        do_reset();
        chk("w_reset_empty", 32'(em2), 32'd1);
        chk("w_reset_fill", 32'(fl2), 32'd0);
        for (int i = 0; i < 7; i++) begin
            wexp[i] = (i == 0) ? 16'h0014 : 16'h0A00 + 16'(i);
            w2 = 1; l2 = (i == 0); d2 = wexp[i];
            @(posedge clk); #1;
            w2 = 0; l2 = 0;
            chk("w_fill_wr", 32'(fl2), 32'(i + 1));
        end
        for (int i = 0; i < 7; i++) begin
            r2 = 1;
            @(posedge clk); #1;
            r2 = 0;
            chk("w_valid", 32'(ov2), 32'd1);
            chk("w_dout", 32'(dout2), 32'(wexp[i]));
            chk("w_pkt_done", 32'(pd2), 32'(i == 6));
            chk("w_fill_rd", 32'(fl2), 32'(6 - i));
        end
        chk("w_empty_end", 32'(em2), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
